// File: rtl/pll_lock_supervisor_pkg.sv
// Shared types and defaults for the PLL lock supervisor: state encoding,
// default parameter values and counter-width helpers.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_e;

  localparam int DEF_RST_HOLD_CYC = 64;
  localparam int DEF_LOCK_TIMEOUT = 50000;
  localparam int DEF_LOCK_STABLE  = 1024;
  localparam int DEF_LOSS_FILTER  = 4;
  localparam int DEF_DOMAIN_GAP   = 16;
  localparam int DEF_N_DOM        = 2;
  localparam int DEF_MAX_RETRY    = 7;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed for a counter whose largest held value is max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// Control/status bundle between the PLL lock supervisor and its surroundings.
interface pll_sup_if
  import pll_sup_pkg::*;
#(
  parameter int N_DOM = DEF_N_DOM
);
  logic             pll_lock_i;
  logic             relock_req_i;
  logic             pll_rst_o;
  logic [N_DOM-1:0] dom_rst_n_o;
  logic             ready_o;
  logic             fail_o;
  logic [3:0]       retry_cnt_o;

  modport master (
    input  pll_lock_i, relock_req_i,
    output pll_rst_o, dom_rst_n_o, ready_o, fail_o, retry_cnt_o
  );

  modport slave (
    output pll_lock_i, relock_req_i,
    input  pll_rst_o, dom_rst_n_o, ready_o, fail_o, retry_cnt_o
  );
endinterface

// File: rtl/pll_lock_supervisor_sync_2ff.sv
// Generic two-flop synchroniser with async reset and a synchronous clear.
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             srst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] sync_r;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= RST_VAL;
      sync_r <= RST_VAL;
    end else if (srst) begin
      meta_r <= RST_VAL;
      sync_r <= RST_VAL;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;
endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock bring-up sequencer: holds the PLL in reset, qualifies lock,
// releases domain resets in order and retries a bounded number of times.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_HOLD_CYC = DEF_RST_HOLD_CYC,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int LOCK_STABLE  = DEF_LOCK_STABLE,
  parameter int LOSS_FILTER  = DEF_LOSS_FILTER,
  parameter int DOMAIN_GAP   = DEF_DOMAIN_GAP,
  parameter int N_DOM        = DEF_N_DOM,
  parameter int MAX_RETRY    = DEF_MAX_RETRY
) (
  input  logic      clk,
  input  logic      rst_n,
  pll_sup_if.master bus
);
  localparam int REL_LAST = (N_DOM - 1) * DOMAIN_GAP;
  localparam int CNT_W    = cnt_width(max2(RST_HOLD_CYC - 1, REL_LAST));
  localparam int TMO_W    = cnt_width(LOCK_TIMEOUT - 1);
  localparam int STAB_W   = cnt_width(LOCK_STABLE - 1);
  localparam int LOSS_W   = cnt_width(LOSS_FILTER - 1);

  localparam logic [CNT_W-1:0]  HOLD_END    = CNT_W'(RST_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0]  REL_END     = CNT_W'(REL_LAST);
  localparam logic [TMO_W-1:0]  TMO_END     = TMO_W'(LOCK_TIMEOUT - 1);
  localparam logic [STAB_W-1:0] STAB_END    = STAB_W'(LOCK_STABLE - 1);
  localparam logic [LOSS_W-1:0] LOSS_END    = LOSS_W'(LOSS_FILTER - 1);
  localparam logic [3:0]        RETRY_LIMIT = 4'(MAX_RETRY);

  state_e            state_r;
  state_e            base_nxt_s;
  state_e            state_nxt_s;
  logic              lock_s;
  logic              fail_evt_s;
  logic              fail_cnt_s;
  logic              enter_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  rel_pos_s;
  logic [TMO_W-1:0]  tmo_r;
  logic [STAB_W-1:0] stab_r;
  logic [LOSS_W-1:0] loss_r;
  logic [3:0]        retry_r;
  logic [3:0]        retry_inc_s;
  logic [3:0]        retry_nxt_s;

  logic              pll_rst_r;
  logic              pll_rst_nxt_s;
  logic [N_DOM-1:0]  dom_r;
  logic [N_DOM-1:0]  dom_nxt_s;
  logic              ready_r;
  logic              ready_nxt_s;
  logic              fail_r;
  logic              fail_nxt_s;

  // LOCK is meaningless while the PLL sits in reset, so the synchroniser is
  // held clear then; every attempt starts counting from a fresh low.
  sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (1'b0)
  ) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .srst  (pll_rst_r),
    .d     (bus.pll_lock_i),
    .q     (lock_s)
  );

  assign retry_inc_s = (retry_r == 4'd15) ? 4'd15 : (retry_r + 4'd1);
  assign fail_cnt_s  = fail_evt_s & ~bus.relock_req_i;
  assign enter_s     = (state_nxt_s != state_r) | bus.relock_req_i | fail_cnt_s;
  assign rel_pos_s   = enter_s ? '0 : (cnt_r + CNT_W'(1));

  // Next-state decision; a restart request overrides any failure this cycle.
  always_comb begin
    base_nxt_s = state_r;
    fail_evt_s = 1'b0;
    case (state_r)
      PLL_RST: begin
        if (cnt_r == HOLD_END) base_nxt_s = WAIT_LOCK;
        else                   base_nxt_s = PLL_RST;
      end
      WAIT_LOCK: begin
        if (lock_s && (stab_r == STAB_END)) base_nxt_s = RELEASE;
        else if (tmo_r == TMO_END)          fail_evt_s = 1'b1;
        else                                base_nxt_s = WAIT_LOCK;
      end
      RELEASE: begin
        if (!lock_s)               fail_evt_s = 1'b1;
        else if (cnt_r == REL_END) base_nxt_s = RUN;
        else                       base_nxt_s = RELEASE;
      end
      RUN: begin
        if (!lock_s && (loss_r == LOSS_END)) fail_evt_s = 1'b1;
        else                                 base_nxt_s = RUN;
      end
      FAIL:    base_nxt_s = FAIL;
      default: base_nxt_s = PLL_RST;
    endcase

    state_nxt_s = base_nxt_s;
    retry_nxt_s = retry_r;
    if (bus.relock_req_i) begin
      state_nxt_s = PLL_RST;
      retry_nxt_s = 4'd0;
    end else if (fail_evt_s) begin
      state_nxt_s = (retry_inc_s >= RETRY_LIMIT) ? FAIL : PLL_RST;
      retry_nxt_s = retry_inc_s;
    end else begin
      state_nxt_s = base_nxt_s;
      retry_nxt_s = retry_r;
    end
  end

  // Output decode from the upcoming state so every output is a flop.
  always_comb begin
    pll_rst_nxt_s = (state_nxt_s == PLL_RST) || (state_nxt_s == FAIL);
    ready_nxt_s   = (state_nxt_s == RUN);
    fail_nxt_s    = (state_nxt_s == FAIL);
    dom_nxt_s     = '0;
    case (state_nxt_s)
      RELEASE: begin
        for (int i = 0; i < N_DOM; i++) begin
          dom_nxt_s[i] = (rel_pos_s >= CNT_W'(i * DOMAIN_GAP));
        end
      end
      RUN:     dom_nxt_s = '1;
      default: dom_nxt_s = '0;
    endcase
  end

  // State register, sequencing counters and retry count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= PLL_RST;
      cnt_r   <= '0;
      tmo_r   <= '0;
      stab_r  <= '0;
      loss_r  <= '0;
      retry_r <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      retry_r <= retry_nxt_s;
      if (enter_s) begin
        cnt_r  <= '0;
        tmo_r  <= '0;
        stab_r <= '0;
        loss_r <= '0;
      end else begin
        if ((state_r == PLL_RST) || (state_r == RELEASE)) cnt_r <= cnt_r + CNT_W'(1);
        if (state_r == WAIT_LOCK) begin
          tmo_r  <= tmo_r + TMO_W'(1);
          stab_r <= lock_s ? (stab_r + STAB_W'(1)) : '0;
        end
        if (state_r == RUN) loss_r <= lock_s ? '0 : (loss_r + LOSS_W'(1));
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pll_rst_r <= 1'b1;
      dom_r     <= '0;
      ready_r   <= 1'b0;
      fail_r    <= 1'b0;
    end else begin
      pll_rst_r <= pll_rst_nxt_s;
      dom_r     <= dom_nxt_s;
      ready_r   <= ready_nxt_s;
      fail_r    <= fail_nxt_s;
    end
  end

  assign bus.pll_rst_o   = pll_rst_r;
  assign bus.dom_rst_n_o = dom_r;
  assign bus.ready_o     = ready_r;
  assign bus.fail_o      = fail_r;
  assign bus.retry_cnt_o = retry_r;
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor: expectations are queued with the
// cycle they are due and compared on the falling edge of that cycle.
module tb_pll_lock_supervisor;
  localparam int SEL_PLLRST = 0;
  localparam int SEL_DOM    = 1;
  localparam int SEL_READY  = 2;
  localparam int SEL_FAIL   = 3;
  localparam int SEL_RETRY  = 4;

  typedef struct {
    int    cyc;
    int    sel;
    int    val;
    string tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc;
  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  pll_sup_if #(.N_DOM(2)) bus ();

  pll_lock_supervisor #(
    .RST_HOLD_CYC (4),
    .LOCK_TIMEOUT (100),
    .LOCK_STABLE  (8),
    .LOSS_FILTER  (3),
    .DOMAIN_GAP   (5),
    .N_DOM        (2),
    .MAX_RETRY    (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Edge count since the last reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string tag, input int obs, input int exp_v);
    checks++;
    if (obs != exp_v) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d (cyc %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  function automatic int observe(input int sel);
    case (sel)
      SEL_PLLRST: return int'(bus.pll_rst_o);
      SEL_DOM:    return int'(bus.dom_rst_n_o);
      SEL_READY:  return int'(bus.ready_o);
      SEL_FAIL:   return int'(bus.fail_o);
      default:    return int'(bus.retry_cnt_o);
    endcase
  endfunction

  task automatic push(input int c, input int sel, input int v, input string tag);
    exp_t e;
    int   pos;
    e.cyc = c; e.sel = sel; e.val = v; e.tag = tag;
    pos = sb.size();
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc > c) pos = i;
    end
    sb.insert(pos, e);
  endtask

  task automatic drain(input int c);
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= c) begin
      e = sb.pop_front();
      check(e.tag, observe(e.sel), e.val);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) drain(cyc);
  end

  task automatic wait_to(input int c);
    int n;
    n = 0;
    while (cyc < c && n < 5000) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (cyc != c) check("wait_to", cyc, c);
  endtask

  task automatic push_reset_state(input int c, input string tag);
    push(c, SEL_PLLRST, 1, {tag, "_pllrst"});
    push(c, SEL_DOM,    0, {tag, "_dom"});
    push(c, SEL_READY,  0, {tag, "_ready"});
    push(c, SEL_FAIL,   0, {tag, "_fail"});
    push(c, SEL_RETRY,  0, {tag, "_retry"});
  endtask

  task automatic do_reset(input logic lock);
    rst_n = 1'b0;
    bus.pll_lock_i   = lock;
    bus.relock_req_i = 1'b0;
    check("sb_empty", sb.size(), 0);
    sb.delete();
    repeat (3) @(posedge clk);
    #2;
    push_reset_state(0, "rst");
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    bus.pll_lock_i   = 1'b0;
    bus.relock_req_i = 1'b0;

    // Clean bring-up with LOCK high from reset release.
    do_reset(1'b1);
    push(3,  SEL_PLLRST, 1, "up_pllrst_hold");
    push(4,  SEL_PLLRST, 0, "up_pllrst_fall");
    push(13, SEL_DOM,    0, "up_dom_early");
    push(14, SEL_DOM,    1, "up_dom0");
    push(18, SEL_DOM,    1, "up_dom_gap");
    push(19, SEL_DOM,    3, "up_dom1");
    push(19, SEL_READY,  0, "up_ready_early");
    push(20, SEL_READY,  1, "up_ready");
    push(20, SEL_FAIL,   0, "up_fail");

    // 2-cycle dip is filtered.
    wait_to(30);
    push(35, SEL_DOM,   3, "dip2_dom");
    push(38, SEL_DOM,   3, "dip2_dom_late");
    push(38, SEL_READY, 1, "dip2_ready");
    bus.pll_lock_i = 1'b0;
    wait_to(32);
    bus.pll_lock_i = 1'b1;

    // 3-cycle dip is a loss: reset domains, count, restart.
    wait_to(40);
    push(44, SEL_DOM,    3, "dip3_dom_hold");
    push(44, SEL_READY,  1, "dip3_ready_hold");
    push(45, SEL_DOM,    0, "dip3_dom_drop");
    push(45, SEL_READY,  0, "dip3_ready_drop");
    push(45, SEL_RETRY,  1, "dip3_retry");
    push(45, SEL_PLLRST, 1, "dip3_pllrst");
    push(48, SEL_PLLRST, 1, "dip3_pllrst_hold");
    push(49, SEL_PLLRST, 0, "dip3_pllrst_fall");
    push(58, SEL_DOM,    0, "dip3_dom_early");
    push(59, SEL_DOM,    1, "dip3_dom0");
    push(64, SEL_DOM,    3, "dip3_dom1");
    push(65, SEL_READY,  1, "dip3_ready");
    push(65, SEL_RETRY,  1, "dip3_retry_keep");
    bus.pll_lock_i = 1'b0;
    wait_to(43);
    bus.pll_lock_i = 1'b1;
    wait_to(70);

    // LOCK never arrives: three timeouts then FAIL.
    do_reset(1'b0);
    push(103, SEL_PLLRST, 0, "tmo_pllrst_low");
    push(103, SEL_RETRY,  0, "tmo_retry0");
    push(104, SEL_RETRY,  1, "tmo_retry1");
    push(104, SEL_PLLRST, 1, "tmo_pllrst1");
    push(107, SEL_PLLRST, 1, "tmo_pllrst_hold");
    push(108, SEL_PLLRST, 0, "tmo_pllrst_fall");
    push(207, SEL_RETRY,  1, "tmo_retry1_keep");
    push(208, SEL_RETRY,  2, "tmo_retry2");
    push(311, SEL_FAIL,   0, "tmo_fail_early");
    push(312, SEL_RETRY,  3, "tmo_retry3");
    push(312, SEL_FAIL,   1, "tmo_fail");
    push(312, SEL_PLLRST, 1, "tmo_fail_pllrst");
    push(312, SEL_DOM,    0, "tmo_fail_dom");
    push(400, SEL_FAIL,   1, "tmo_fail_sticky");
    push(400, SEL_PLLRST, 1, "tmo_pllrst_sticky");
    push(400, SEL_RETRY,  3, "tmo_retry_sat");
    wait_to(400);

    // Restart from FAIL.
    push(401, SEL_FAIL,   0, "rec_fail_clr");
    push(401, SEL_RETRY,  0, "rec_retry_clr");
    push(401, SEL_PLLRST, 1, "rec_pllrst");
    push(405, SEL_PLLRST, 0, "rec_pllrst_fall");
    push(414, SEL_DOM,    0, "rec_dom_early");
    push(415, SEL_DOM,    1, "rec_dom0");
    push(420, SEL_DOM,    3, "rec_dom1");
    push(421, SEL_READY,  1, "rec_ready");
    push(421, SEL_FAIL,   0, "rec_fail");
    bus.relock_req_i = 1'b1;
    bus.pll_lock_i   = 1'b1;
    wait_to(401);
    bus.relock_req_i = 1'b0;
    wait_to(425);

    // Lock bounce: stable count restarts after the drop.
    do_reset(1'b0);
    push(14, SEL_DOM,   0, "bnc_dom_a");
    push(17, SEL_DOM,   0, "bnc_dom_norestart");
    push(21, SEL_DOM,   0, "bnc_dom_early");
    push(22, SEL_DOM,   1, "bnc_dom0");
    push(27, SEL_DOM,   3, "bnc_dom1");
    push(28, SEL_READY, 1, "bnc_ready");
    wait_to(6);
    bus.pll_lock_i = 1'b1;
    wait_to(11);
    bus.pll_lock_i = 1'b0;
    wait_to(12);
    bus.pll_lock_i = 1'b1;
    wait_to(30);

    // Asynchronous reset while half the domains are released.
    do_reset(1'b1);
    push(14, SEL_DOM, 1, "arst_dom0");
    push(16, SEL_DOM, 1, "arst_dom_pre");
    wait_to(16);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    push_reset_state(-1, "arst");
    drain(-1);
    #10;

    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
